mac_prbs_frame_gen: RTL and testbench
=====================================

Name: mac_prbs_frame_gen

Overview:
Parametrised successor to the fixed-format MAC PRBS source. It generates framed AXI-stream traffic toward the GTF MAC TX in MAC mode. The payload is a continuous parallel PRBS, so the existing PRBS checker on RX can lock across frames. Frame length, inter-frame gap, frame count and preamble byte are runtime/parameter programmable, which the fixed 3-beat tlast scheme could not do.

Parameters:
WIDTH, 64, data bus bits; multiple of 8, range 16..64; BYTES = WIDTH/8.
LEN_W, 14, width of frame-length config (bytes).
PREAMBLE_BYTE, 8'h03, value driven on pre_data_out during SOF beat.
PRBS_ORDER, 31, PRBS polynomial: 7 (x^7+x^6+1), 15 (x^15+x^14+1), 23 (x^23+x^18+1), 31 (x^31+x^28+1).
CNT_W, 32, width of frames_sent counter.

Ports:
txclk  in  1  single clock for all logic
txrst_n  in  1  reset, synchronous, active-low
cfg_start  in  1  pulse; starts a run when IDLE or DONE
cfg_stop  in  1  pulse; graceful stop after current frame
cfg_frame_len  in  LEN_W  frame length in bytes; sampled at each SOF
cfg_ifg_cycles  in  8  idle cycles between frames; sampled at each SOF
cfg_frame_count  in  16  frames per run; 0 = continuous; sampled at start
txaxistready  in  1  MAC ready
txaxistvalid  out  1  beat valid
txaxistdata  out  WIDTH  PRBS payload
txaxistlast  out  BYTES  one-hot last-byte position; 0 on non-last beats
txaxissof  out  1  high on first beat of frame
pre_data_out  out  8  PREAMBLE_BYTE on SOF beat, else 0
busy  out  1  high in PRE/DATA/IFG
done  out  1  high in DONE
frames_sent  out  CNT_W  frames completed this run, saturating

Behaviour:
- Reset (txrst_n=0 at edge): state IDLE; all outputs 0; PRBS register all-ones; frames_sent 0; stop latch cleared. A reset mid-frame aborts immediately, with no tlast emitted.
- Accept = txaxistvalid & txaxistready. While valid & !ready, data/last/sof/pre_data_out are held stable. Valid never drops before accept.
- Length: L = max(cfg_frame_len, 64). Beats N = ceil(L/BYTES). Last beat txaxistlast = 1 << ((L-1) mod BYTES).
- FSM:
  - IDLE --cfg_start--> SOF. Clear frames_sent; latch cfg_frame_count.
  - SOF: valid=1, sof=1, pre_data_out=PREAMBLE_BYTE, beat 0. On accept -> DATA.
  - DATA: beats 1..N-1; on accept of last beat -> IFG, or DONE if stop condition holds.
  - IFG: valid=0 for cfg_ifg_cycles cycles, then SOF. When ifg=0, SOF is asserted the cycle after last-beat accept.
  - DONE: done=1; cfg_start -> SOF with the same clearing as from IDLE.
- Latency: cfg_start sampled at edge t -> valid/sof high after edge t (visible cycle t+1).
- Stop condition: stop latch set, or latched count≠0 and frames_sent+1 == count at last-beat accept.
- cfg_stop latches in any busy state and clears on entry to DONE. cfg_stop in IDLE/DONE is ignored.
- cfg_start while busy is ignored. Simultaneous start+stop in IDLE: start wins; stop is ignored.
- PRBS: WIDTH bits per beat, bit 0 = earliest, self-synchronous Fibonacci form. Advances only on accept. It is not reseeded per frame and continues across frames and IFG. It is reseeded to all-ones on start from IDLE/DONE.
- frames_sent increments on last-beat accept and saturates at 2^CNT_W-1.

Test Plan:
- WIDTH=64, len=64, ifg=0, count=2, ready=1 -> 8 beats/frame; sof on beats 0,8; last=8'h80 on beats 7,15; frames_sent=2; done one cycle after beat 15.
- len=67, ifg=3 -> 9 beats; last=8'h04; exactly 3 valid-low cycles between frames.
- len=20 -> clamped to 64: 8 beats, last=8'h80.
- Ready toggled pseudo-randomly mid-frame -> outputs stable while stalled. Concatenated accepted data equals reference PRBS31 seeded all-ones, with no gaps across frames.
- count=0, cfg_stop at beat 3 of frame 5 -> frame 5 completes, done asserts, frames_sent=5; a second cfg_stop while busy has no extra effect.
- txrst_n low at beat 4 -> next cycle all outputs 0, state IDLE. A subsequent cfg_start restarts PRBS from all-ones with frames_sent=0.

Source files
------------

// File: rtl/mac_prbs_frame_gen.sv
// mac_prbs_frame_gen
// Framed AXI-stream PRBS source for the GTF MAC TX path in MAC mode.
// Each frame is a run of WIDTH-bit beats drawn from one continuous PRBS.
// The PRBS is never reseeded between frames, so an RX checker stays locked.
// Frame length, inter-frame gap, frame count and preamble byte are programmable.

module mac_prbs_frame_gen #(
    parameter int         WIDTH         = 64,
    parameter int         LEN_W         = 14,
    parameter logic [7:0] PREAMBLE_BYTE = 8'h03,
    parameter int         PRBS_ORDER    = 31,
    parameter int         CNT_W         = 32
) (
    input  logic                 txclk,
    input  logic                 txrst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [LEN_W-1:0]     cfg_frame_len,
    input  logic [7:0]           cfg_ifg_cycles,
    input  logic [15:0]          cfg_frame_count,
    input  logic                 txaxistready,
    output logic                 txaxistvalid,
    output logic [WIDTH-1:0]     txaxistdata,
    output logic [WIDTH/8-1:0]   txaxistlast,
    output logic                 txaxissof,
    output logic [7:0]           pre_data_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     frames_sent
);

    localparam int BYTES = WIDTH / 8;
    localparam int TAP   = (PRBS_ORDER == 7)  ? 6  :
                           (PRBS_ORDER == 15) ? 14 :
                           (PRBS_ORDER == 23) ? 18 : 28;
    localparam int CMP_W = ((CNT_W > 16) ? CNT_W : 16) + 1;

    localparam logic [LEN_W-1:0]      MIN_LEN   = LEN_W'(64);
    localparam logic [LEN_W-1:0]      BYTES_LEN = LEN_W'(BYTES);
    localparam logic [PRBS_ORDER-1:0] PRBS_SEED = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_IFG,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [PRBS_ORDER-1:0]   prbs_q;
    logic                    valid_q;
    logic [WIDTH-1:0]        data_q;
    logic [BYTES-1:0]        last_q;
    logic                    sof_q;
    logic [7:0]              pre_q;
    logic                    busy_q;
    logic                    done_q;
    logic [CNT_W-1:0]        frames_q;
    logic [15:0]             count_q;
    logic                    stop_q;
    logic [LEN_W-1:0]        rem_q;
    logic [7:0]              ifg_q;
    logic [7:0]              ifgCnt_q;

    logic [WIDTH-1:0]        runData_d;
    logic [PRBS_ORDER-1:0]   runState_d;
    logic [WIDTH-1:0]        seedData_d;
    logic [PRBS_ORDER-1:0]   seedState_d;
    logic [LEN_W-1:0]        frameLen_d;
    logic [LEN_W-1:0]        remNext_d;
    logic [CNT_W-1:0]        framesInc_d;
    logic                    accept_d;
    logic                    isLastBeat_d;
    logic                    countHit_d;
    logic                    stopHit_d;

    // Runs the Fibonacci LFSR WIDTH steps; bit 0 of the beat is the earliest bit.
    // Returns {state after the beat, beat data}.
    function automatic logic [PRBS_ORDER+WIDTH-1:0] prbsAdvance(input logic [PRBS_ORDER-1:0] seed);
        logic [PRBS_ORDER-1:0] s;
        logic [WIDTH-1:0]      d;
        logic                  fb;
        s = seed;
        d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fb   = s[PRBS_ORDER-1] ^ s[TAP-1];
            d[i] = fb;
            s    = {s[PRBS_ORDER-2:0], fb};
        end
        return {s, d};
    endfunction

    // One-hot position of the final byte when rem bytes are left in the frame.
    function automatic logic [BYTES-1:0] lastMask(input logic [LEN_W-1:0] rem);
        logic [BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (rem == LEN_W'(i + 1));
        end
        return m;
    endfunction

    assign {runState_d, runData_d}   = prbsAdvance(prbs_q);
    assign {seedState_d, seedData_d} = prbsAdvance(PRBS_SEED);

    assign frameLen_d   = (cfg_frame_len < MIN_LEN) ? MIN_LEN : cfg_frame_len;
    assign remNext_d    = rem_q - BYTES_LEN;
    assign accept_d     = valid_q & txaxistready;
    assign isLastBeat_d = (rem_q <= BYTES_LEN);
    assign framesInc_d  = (&frames_q) ? frames_q : frames_q + CNT_W'(1);
    assign countHit_d   = (count_q != 16'd0) &&
                          ((CMP_W'(frames_q) + CMP_W'(1)) == CMP_W'(count_q));
    assign stopHit_d    = stop_q | cfg_stop | countHit_d;

    // Frame sequencer: every output is a register so that stalled beats stay stable.
    // The PRBS register always holds the state after the beat currently on the bus,
    // so it moves forward exactly once per presented (and later accepted) beat.
    always_ff @(posedge txclk) begin
        if (!txrst_n) begin
            state_q  <= S_IDLE;
            prbs_q   <= PRBS_SEED;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= '0;
            sof_q    <= 1'b0;
            pre_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
            count_q  <= '0;
            stop_q   <= 1'b0;
            rem_q    <= '0;
            ifg_q    <= '0;
            ifgCnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        frames_q <= '0;
                        count_q  <= cfg_frame_count;
                        stop_q   <= 1'b0;
                        prbs_q   <= seedState_d;
                        data_q   <= seedData_d;
                        state_q  <= S_SOF;
                        valid_q  <= 1'b1;
                        sof_q    <= 1'b1;
                        pre_q    <= PREAMBLE_BYTE;
                        last_q   <= '0;
                        rem_q    <= frameLen_d;
                        ifg_q    <= cfg_ifg_cycles;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                S_SOF: begin
                    if (cfg_stop) begin
                        stop_q <= 1'b1;
                    end
                    if (accept_d) begin
                        state_q <= S_DATA;
                        sof_q   <= 1'b0;
                        pre_q   <= '0;
                        prbs_q  <= runState_d;
                        data_q  <= runData_d;
                        rem_q   <= remNext_d;
                        last_q  <= lastMask(remNext_d);
                    end
                end
                S_DATA: begin
                    if (cfg_stop) begin
                        stop_q <= 1'b1;
                    end
                    if (accept_d) begin
                        if (isLastBeat_d) begin
                            frames_q <= framesInc_d;
                            if (stopHit_d) begin
                                state_q <= S_DONE;
                                valid_q <= 1'b0;
                                data_q  <= '0;
                                last_q  <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                stop_q  <= 1'b0;
                            end else if (ifg_q == 8'd0) begin
                                prbs_q  <= runState_d;
                                data_q  <= runData_d;
                                state_q <= S_SOF;
                                sof_q   <= 1'b1;
                                pre_q   <= PREAMBLE_BYTE;
                                last_q  <= '0;
                                rem_q   <= frameLen_d;
                                ifg_q   <= cfg_ifg_cycles;
                            end else begin
                                state_q  <= S_IFG;
                                valid_q  <= 1'b0;
                                data_q   <= '0;
                                last_q   <= '0;
                                ifgCnt_q <= ifg_q - 8'd1;
                            end
                        end else begin
                            prbs_q <= runState_d;
                            data_q <= runData_d;
                            rem_q  <= remNext_d;
                            last_q <= lastMask(remNext_d);
                        end
                    end
                end
                S_IFG: begin
                    if (cfg_stop) begin
                        stop_q <= 1'b1;
                    end
                    if (ifgCnt_q == 8'd0) begin
                        prbs_q  <= runState_d;
                        data_q  <= runData_d;
                        state_q <= S_SOF;
                        valid_q <= 1'b1;
                        sof_q   <= 1'b1;
                        pre_q   <= PREAMBLE_BYTE;
                        last_q  <= '0;
                        rem_q   <= frameLen_d;
                        ifg_q   <= cfg_ifg_cycles;
                    end else begin
                        ifgCnt_q <= ifgCnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txaxistvalid = valid_q;
    assign txaxistdata  = data_q;
    assign txaxistlast  = last_q;
    assign txaxissof    = sof_q;
    assign pre_data_out = pre_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_mac_prbs_frame_gen.sv
// tb_mac_prbs_frame_gen
// Directed and randomized scenarios for the framed PRBS source. Expected beats
// come from a bit-level PRBS31 recurrence (b[n] = b[n-31] ^ b[n-28], history
// seeded with ones) sliced into frames from the length rules.

module tb_mac_prbs_frame_gen;

    localparam int         WIDTH = 64;
    localparam int         BYTES = 8;
    localparam logic [7:0] PRE   = 8'h03;

    logic               txclk = 1'b0;
    logic               txrst_n;
    logic               cfg_start;
    logic               cfg_stop;
    logic [13:0]        cfg_frame_len;
    logic [7:0]         cfg_ifg_cycles;
    logic [15:0]        cfg_frame_count;
    logic               txaxistready;
    logic               txaxistvalid;
    logic [WIDTH-1:0]   txaxistdata;
    logic [BYTES-1:0]   txaxistlast;
    logic               txaxissof;
    logic [7:0]         pre_data_out;
    logic               busy;
    logic               done;
    logic [31:0]        frames_sent;

    int total = 0;
    int bad   = 0;
    int cycleNo = 0;
    int doneCycle = -1;

    logic [WIDTH-1:0] capData[$];
    logic [BYTES-1:0] capLast[$];
    logic             capSof[$];
    logic [7:0]       capPre[$];
    int               capCycle[$];

    logic [WIDTH-1:0] expData[$];
    logic [BYTES-1:0] expLast[$];
    logic             expSof[$];
    logic [7:0]       expPre[$];

    bit               prbsHist[$];
    logic             stallPending = 1'b0;
    logic [127:0]     heldBeat;
    bit               stop1Sent;
    bit               stop2Sent;
    logic             stopNow;
    int               loops;
    int               rndLen;
    int               rndIfg;

    // Free-running 100 MHz clock
    always #5 txclk = ~txclk;

    mac_prbs_frame_gen #(
        .WIDTH(WIDTH), .LEN_W(14), .PREAMBLE_BYTE(PRE), .PRBS_ORDER(31), .CNT_W(32)
    ) dut (
        .txclk(txclk), .txrst_n(txrst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_frame_len(cfg_frame_len), .cfg_ifg_cycles(cfg_ifg_cycles),
        .cfg_frame_count(cfg_frame_count), .txaxistready(txaxistready),
        .txaxistvalid(txaxistvalid), .txaxistdata(txaxistdata), .txaxistlast(txaxistlast),
        .txaxissof(txaxissof), .pre_data_out(pre_data_out), .busy(busy), .done(done),
        .frames_sent(frames_sent)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit nextPrbsBit();
        int n;
        bit b;
        n = prbsHist.size();
        b = prbsHist[n-31] ^ prbsHist[n-28];
        prbsHist.push_back(b);
        return b;
    endfunction

    task automatic modelReseed();
        prbsHist.delete();
        repeat (31) prbsHist.push_back(1'b1);
        expData.delete();
        expLast.delete();
        expSof.delete();
        expPre.delete();
    endtask

    task automatic buildExpected(input int len, input int frames);
        int l;
        int nb;
        logic [WIDTH-1:0] d;
        logic [BYTES-1:0] one;
        one = 1;
        l  = (len < 64) ? 64 : len;
        nb = (l + BYTES - 1) / BYTES;
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < WIDTH; i++) d[i] = nextPrbsBit();
                expData.push_back(d);
                expLast.push_back((b == nb - 1) ? (one << ((l - 1) % BYTES)) : '0);
                expSof.push_back(b == 0);
                expPre.push_back((b == 0) ? PRE : 8'h00);
            end
        end
    endtask

    task automatic clearCapture();
        capData.delete();
        capLast.delete();
        capSof.delete();
        capPre.delete();
        capCycle.delete();
        stallPending = 1'b0;
        doneCycle = -1;
    endtask

    // Called at a falling edge: drive inputs, sample outputs, step to next falling edge
    task automatic applyStimulus(input logic start, input logic stop, input logic ready);
        logic [127:0] curBeat;
        cfg_start    = start;
        cfg_stop     = stop;
        txaxistready = ready;
        curBeat = 128'({txaxistvalid, txaxissof, pre_data_out, txaxistlast, txaxistdata});
        if (stallPending) checkOutput("stall_hold", curBeat, heldBeat);
        if (txaxistvalid && txaxistready) begin
            capData.push_back(txaxistdata);
            capLast.push_back(txaxistlast);
            capSof.push_back(txaxissof);
            capPre.push_back(pre_data_out);
            capCycle.push_back(cycleNo);
        end
        stallPending = txaxistvalid && !txaxistready;
        heldBeat = curBeat;
        cycleNo++;
        @(negedge txclk);
        if (done && doneCycle < 0) doneCycle = cycleNo;
    endtask

    task automatic runUntilDone(input int budget, input bit randomReady);
        int n;
        n = 0;
        while (!done && n < budget) begin
            applyStimulus(1'b0, 1'b0, randomReady ? ($urandom_range(0, 3) != 0) : 1'b1);
            n++;
        end
        checkOutput("reached_done", 128'(done), 128'(1));
    endtask

    task automatic compareRun(input string name);
        int n;
        checkOutput({name, "_beats"}, 128'(capData.size()), 128'(expData.size()));
        n = (capData.size() < expData.size()) ? capData.size() : expData.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_data%0d", name, i), 128'(capData[i]), 128'(expData[i]));
            checkOutput($sformatf("%s_last%0d", name, i), 128'(capLast[i]), 128'(expLast[i]));
            checkOutput($sformatf("%s_sof%0d", name, i), 128'(capSof[i]), 128'(expSof[i]));
            checkOutput($sformatf("%s_pre%0d", name, i), 128'(capPre[i]), 128'(expPre[i]));
        end
    endtask

    task automatic startRun(input int len, input int ifg, input int count);
        cfg_frame_len   = 14'(len);
        cfg_ifg_cycles  = 8'(ifg);
        cfg_frame_count = 16'(count);
        clearCapture();
        modelReseed();
        applyStimulus(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        txrst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_frame_len = '0;
        cfg_ifg_cycles = '0;
        cfg_frame_count = '0;
        txaxistready = 1'b1;
        @(negedge txclk);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] reset state");
        checkOutput("rst_valid", 128'(txaxistvalid), 128'(0));
        checkOutput("rst_data", 128'(txaxistdata), 128'(0));
        checkOutput("rst_last", 128'(txaxistlast), 128'(0));
        checkOutput("rst_sof", 128'(txaxissof), 128'(0));
        checkOutput("rst_pre", 128'(pre_data_out), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_frames", 128'(frames_sent), 128'(0));
        txrst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("idle_stop_ignored", 128'({busy, done, txaxistvalid}), 128'(0));

        $display("[TB] len=64 ifg=0 count=2");
        startRun(64, 0, 2);
        checkOutput("t1_valid_latency", 128'(txaxistvalid), 128'(1));
        checkOutput("t1_sof_latency", 128'(txaxissof), 128'(1));
        checkOutput("t1_busy", 128'(busy), 128'(1));
        checkOutput("t1_frames_cleared", 128'(frames_sent), 128'(0));
        applyStimulus(1'b1, 1'b0, 1'b1);
        buildExpected(64, 2);
        runUntilDone(200, 1'b0);
        compareRun("t1");
        checkOutput("t1_frames", 128'(frames_sent), 128'(2));
        checkOutput("t1_busy_end", 128'(busy), 128'(0));
        checkOutput("t1_contiguous",
                    128'((capCycle.size() == 16) ? capCycle[15] - capCycle[0] : -1), 128'(15));
        checkOutput("t1_done_timing",
                    128'((capCycle.size() > 0) ? doneCycle - capCycle[capCycle.size()-1] : -1), 128'(1));

        $display("[TB] len=67 ifg=3 count=2");
        startRun(67, 3, 2);
        buildExpected(67, 2);
        runUntilDone(200, 1'b0);
        compareRun("t2");
        checkOutput("t2_frames", 128'(frames_sent), 128'(2));
        checkOutput("t2_gap",
                    128'((capCycle.size() >= 10) ? capCycle[9] - capCycle[8] : -1), 128'(4));

        $display("[TB] len=20 clamps to 64");
        startRun(20, 0, 1);
        buildExpected(20, 1);
        runUntilDone(200, 1'b0);
        compareRun("t3");
        checkOutput("t3_frames", 128'(frames_sent), 128'(1));

        rndLen = $urandom_range(64, 160);
        rndIfg = $urandom_range(0, 3);
        $display("[TB] random ready, len=%0d ifg=%0d count=3", rndLen, rndIfg);
        startRun(rndLen, rndIfg, 3);
        buildExpected(rndLen, 3);
        runUntilDone(3000, 1'b1);
        compareRun("t4");
        checkOutput("t4_frames", 128'(frames_sent), 128'(3));

        $display("[TB] continuous run stopped in frame 5");
        startRun(64, 0, 0);
        buildExpected(64, 5);
        stop1Sent = 0;
        stop2Sent = 0;
        loops = 0;
        while (!done && loops < 500) begin
            stopNow = 1'b0;
            if (capData.size() == 35 && !stop1Sent) begin stopNow = 1'b1; stop1Sent = 1; end
            if (capData.size() == 37 && !stop2Sent) begin stopNow = 1'b1; stop2Sent = 1; end
            applyStimulus(1'b0, stopNow, 1'b1);
            loops++;
        end
        checkOutput("t5_done", 128'(done), 128'(1));
        compareRun("t5");
        checkOutput("t5_frames", 128'(frames_sent), 128'(5));
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5_quiet_after_done", 128'({done, txaxistvalid, 32'(capData.size())}),
                    128'({1'b1, 1'b0, 32'd40}));

        $display("[TB] reset mid-frame");
        startRun(64, 0, 0);
        loops = 0;
        while (capData.size() < 4 && loops < 50) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            loops++;
        end
        checkOutput("t6_reached_beat4", 128'(capData.size()), 128'(4));
        txrst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        txrst_n = 1'b1;
        checkOutput("t6_rst_valid", 128'(txaxistvalid), 128'(0));
        checkOutput("t6_rst_data", 128'(txaxistdata), 128'(0));
        checkOutput("t6_rst_last_sof_pre", 128'({txaxistlast, txaxissof, pre_data_out}), 128'(0));
        checkOutput("t6_rst_busy_done", 128'({busy, done}), 128'(0));
        checkOutput("t6_rst_frames", 128'(frames_sent), 128'(0));
        startRun(64, 0, 1);
        checkOutput("t6_restart_frames", 128'(frames_sent), 128'(0));
        buildExpected(64, 1);
        runUntilDone(200, 1'b0);
        compareRun("t6");
        checkOutput("t6_frames", 128'(frames_sent), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
